// File: rtl/fp_pkg.sv
// Shared double-precision constants and a width helper for the multiplier-sharing logic.
package fp_pkg;

  localparam int unsigned FP_W = 64;
  localparam logic [FP_W-1:0] FP_ONE = 64'h3FF0_0000_0000_0000;

  // Index width for a set of n items; never below one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = tag_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((32'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/fpmul_share_ctrl.sv
// Shares one AXI-stream double multiplier among N_REQ requesters.
// Round-robin issue through a single slot; results are routed back in issue order via a tag FIFO.
module fpmul_share_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = FP_W,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        res_vld,
  output logic [DATA_W-1:0]       res_data,
  output logic                    mul_a_tvalid,
  output logic                    mul_b_tvalid,
  output logic [DATA_W-1:0]       mul_a_tdata,
  output logic [DATA_W-1:0]       mul_b_tdata,
  input  logic                    mul_a_tready,
  input  logic                    mul_b_tready,
  input  logic                    mul_res_tvalid,
  input  logic [DATA_W-1:0]       mul_res_tdata,
  output logic                    mul_res_tready,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int unsigned TAG_W = tag_w(N_REQ);
  localparam int unsigned PTR_W = tag_w(MAX_INFLIGHT);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic                slot_v_q, slot_v_d;
  logic [DATA_W-1:0]   slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic [CNT_W-1:0]    credits_q, credits_d;
  logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]    fifo_mem_q [MAX_INFLIGHT];
  logic [N_REQ-1:0]    res_vld_q, res_vld_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                err_q, err_d;

  logic                accept, load, pop, arb_en;
  logic [N_REQ-1:0]    arb_gnt;
  logic [TAG_W-1:0]    arb_next, win_tag;
  logic [DATA_W-1:0]   win_a, win_b;

  assign accept = slot_v_q & mul_a_tready & mul_b_tready;
  // Grants are suppressed while reset is held so gnt reads zero in reset.
  assign arb_en = rst_n & (credits_q != '0) & (~slot_v_q | accept);
  assign load   = |arb_gnt;
  assign pop    = mul_res_tvalid & (cnt_q != '0);

  rr_arbiter #(.N(N_REQ), .PW(TAG_W)) u_arb (
    .req      (req),
    .ptr      (rr_ptr_q),
    .en       (arb_en),
    .gnt      (arb_gnt),
    .next_ptr (arb_next)
  );

  // Encode the one-hot grant into a tag and select the winner's operands.
  always_comb begin
    win_tag = '0;
    win_a   = '0;
    win_b   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_tag = TAG_W'(i);
        win_a   = req_a[i*DATA_W +: DATA_W];
        win_b   = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    slot_v_d   = slot_v_q;
    slot_a_d   = slot_a_q;
    slot_b_d   = slot_b_q;
    credits_d  = credits_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(load);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    res_vld_d  = '0;
    res_data_d = res_data_q;
    err_d      = err_q | (mul_res_tvalid & (cnt_q == '0));

    if (load) begin
      slot_v_d = 1'b1;
      slot_a_d = win_a;
      slot_b_d = win_b;
      rr_ptr_d = arb_next;
    end else if (accept) begin
      slot_v_d = 1'b0;
    end

    // Credits and FIFO occupancy move in opposite directions on push/pop.
    case ({load, pop})
      2'b10: begin
        credits_d = credits_q - CNT_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        credits_d = credits_q + CNT_W'(1);
        cnt_d     = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    if (pop) begin
      res_vld_d[fifo_mem_q[rd_ptr_q]] = 1'b1;
      res_data_d                      = mul_res_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q   <= 1'b0;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      credits_q  <= CNT_W'(MAX_INFLIGHT);
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      res_vld_q  <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      credits_q  <= credits_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (load) fifo_mem_q[wr_ptr_q] <= win_tag;
  end

  assign gnt            = arb_gnt;
  assign res_vld        = res_vld_q;
  assign res_data       = res_data_q;
  assign mul_a_tvalid   = slot_v_q;
  assign mul_b_tvalid   = slot_v_q;
  assign mul_a_tdata    = slot_a_q;
  assign mul_b_tdata    = slot_b_q;
  assign mul_res_tready = 1'b1;
  assign busy           = (credits_q != CNT_W'(MAX_INFLIGHT)) | slot_v_q;
  assign err_orphan     = err_q;

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: multiplier model with latency, queue-based reference model, directed tests.
module tb_fpmul_share_ctrl;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    gnt, res_vld;
  logic [W-1:0]    res_data, mul_a_tdata, mul_b_tdata;
  logic            mul_a_tvalid, mul_b_tvalid, mul_res_tready, busy, err_orphan;
  logic            mul_a_tready = 1'b1;
  logic            mul_b_tready = 1'b1;
  logic            mul_res_tvalid = 1'b0;
  logic [W-1:0]    mul_res_tdata = '0;

  fpmul_share_ctrl #(.N_REQ(N), .DATA_W(W), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .res_vld(res_vld), .res_data(res_data),
    .mul_a_tvalid(mul_a_tvalid), .mul_b_tvalid(mul_b_tvalid),
    .mul_a_tdata(mul_a_tdata), .mul_b_tdata(mul_b_tdata),
    .mul_a_tready(mul_a_tready), .mul_b_tready(mul_b_tready),
    .mul_res_tvalid(mul_res_tvalid), .mul_res_tdata(mul_res_tdata),
    .mul_res_tready(mul_res_tready), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] fp(input int v);
    return $realtobits(real'(v));
  endfunction

  // Multiplier model: accepted operands return their product mul_lat cycles later.
  typedef struct { int due; logic [63:0] d; } mres_t;
  mres_t mq[$];
  int    cyc = 0;
  int    mul_lat = 4;

  always @(negedge clk) begin
    if (mul_a_tvalid && mul_a_tready && mul_b_tready)
      mq.push_back('{cyc + mul_lat, fmul(mul_a_tdata, mul_b_tdata)});
  end

  always @(posedge clk) begin
    #3;
    cyc++;
    mul_res_tvalid = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mul_res_tvalid = 1'b1;
      mul_res_tdata  = mq[0].d;
      void'(mq.pop_front());
    end
  end

  // Requester driver: each requester walks its own list of operand pairs, holding until granted.
  logic [63:0] op_a [N][8];
  logic [63:0] op_b [N][8];
  int          op_n [N];
  int          op_i [N];
  logic [N-1:0] gl = '0;

  initial for (int i = 0; i < N; i++) begin op_n[i] = 0; op_i[i] = 0; end

  always @(negedge clk) gl = gnt;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (gl[i]) op_i[i]++;
      if (op_i[i] < op_n[i]) begin
        req[i] = 1'b1;
        req_a[i*W +: W] = op_a[i][op_i[i]];
        req_b[i*W +: W] = op_b[i][op_i[i]];
      end else begin
        req[i] = 1'b0;
      end
    end
  end

  task automatic add_op(input int r, input logic [63:0] a, input logic [63:0] b);
    op_a[r][op_n[r]] = a;
    op_b[r][op_n[r]] = b;
    op_n[r]++;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (op_i[i] < op_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: credits, one issue slot, in-order queue of (owner, product).
  typedef struct { int owner; logic [63:0] prod; } infl_t;
  infl_t        infl[$];
  int           m_credits = MAX;
  int           m_rr = 0;
  bit           m_slot_v = 1'b0;
  logic [63:0]  m_sa = '0, m_sb = '0;
  bit           m_err = 1'b0;
  bit           m_pend = 1'b0;
  infl_t        m_pe;

  always @(negedge clk) begin : model_p
    logic [N-1:0] eg, er;
    int           win;
    bit           acc;
    if (!rst_n) begin
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_res_vld", 64'(res_vld), 64'(0));
      chk("rst_res_data", res_data, 64'(0));
      chk("rst_tvalid", 64'({mul_a_tvalid, mul_b_tvalid}), 64'(0));
      chk("rst_tdata_a", mul_a_tdata, 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err_orphan), 64'(0));
      m_credits = MAX; m_rr = 0; m_slot_v = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      infl.delete();
    end else begin
      acc = m_slot_v && mul_a_tready && mul_b_tready;
      win = -1;
      if (m_credits > 0 && (!m_slot_v || acc))
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      er = '0;
      if (m_pend) er[m_pe.owner] = 1'b1;

      chk("gnt", 64'(gnt), 64'(eg));
      chk("tvalid_a", 64'(mul_a_tvalid), 64'(m_slot_v));
      chk("tvalid_b", 64'(mul_b_tvalid), 64'(m_slot_v));
      if (m_slot_v) begin
        chk("tdata_a", mul_a_tdata, m_sa);
        chk("tdata_b", mul_b_tdata, m_sb);
      end
      chk("busy", 64'(busy), 64'(m_credits < MAX || m_slot_v));
      chk("err_orphan", 64'(err_orphan), 64'(m_err));
      chk("res_tready", 64'(mul_res_tready), 64'(1));
      chk("res_vld", 64'(res_vld), 64'(er));
      if (m_pend) chk("res_data", res_data, m_pe.prod);

      m_pend = 1'b0;
      if (mul_res_tvalid) begin
        if (infl.size() > 0) begin
          m_pe = infl.pop_front();
          m_pend = 1'b1;
          m_credits++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (win >= 0) begin
        m_sa = req_a[win*W +: W];
        m_sb = req_b[win*W +: W];
        m_slot_v = 1'b1;
        infl.push_back('{win, fmul(m_sa, m_sb)});
        m_credits--;
        m_rr = (win + 1) % N;
      end else if (acc) begin
        m_slot_v = 1'b0;
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && mq.size() == 0 && !mul_res_tvalid && all_done()) break;
    end
    chk("idle_reached", 64'(t < 300), 64'(1));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    drive_edge();
    rst_n = 1'b0;
    @(negedge clk);
    drive_edge();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int n;
    int t;
    repeat (3) @(negedge clk);
    chk("init_busy", 64'(busy), 64'(0));
    drive_edge();
    rst_n = 1'b1;

    // Single op: 2.0 * 3.0 -> 6.0
    mul_lat = 8;
    drive_edge();
    add_op(0, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
    for (t = 0; t < 10; t++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    chk("t1_gnt", 64'(gnt), 64'(4'b0001));
    @(negedge clk);
    chk("t1_tdata_a", mul_a_tdata, 64'h4000_0000_0000_0000);
    for (t = 0; t < 30; t++) begin
      @(negedge clk);
      if (res_vld != '0) break;
    end
    chk("t1_res_vld", 64'(res_vld), 64'(4'b0001));
    chk("t1_res_data", res_data, 64'h4018_0000_0000_0000);
    wait_idle();

    // Round-robin with everyone requesting from rr_ptr=0
    pulse_reset();
    mul_lat = 1;
    drive_edge();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) add_op(i, fp(i + 1), fp(k + 2));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_rr_gnt", 64'(gnt), 64'(1) << (k % N));
    end
    wait_idle();

    // Credit exhaustion: exactly MAX grants before the first result
    mul_lat = 20;
    drive_edge();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) add_op(i, fp(i + 3), fp(k + 5));
    n = 0;
    for (t = 0; t < 80; t++) begin
      @(negedge clk);
      if (gnt != '0) n++;
      if (mul_res_tvalid) break;
    end
    chk("t3_grants_before_ret", 64'(n), 64'(4));
    @(negedge clk);
    chk("t3_fifth_gnt", 64'(gnt), 64'(4'b0001));
    wait_idle();

    // Stall: tready low holds the slot
    mul_lat = 4;
    drive_edge();
    mul_a_tready = 1'b0;
    add_op(1, 64'h4014_0000_0000_0000, 64'h4000_0000_0000_0000);
    add_op(2, 64'h401C_0000_0000_0000, 64'h4000_0000_0000_0000);
    @(negedge clk);
    chk("t4_first_gnt", 64'(gnt), 64'(4'b0010));
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_tvalid", 64'(mul_a_tvalid), 64'(1));
      chk("t4_stall_tdata", mul_a_tdata, 64'h4014_0000_0000_0000);
      chk("t4_stall_gnt", 64'(gnt), 64'(0));
    end
    drive_edge();
    mul_a_tready = 1'b1;
    @(negedge clk);
    chk("t4_gnt_on_accept", 64'(gnt), 64'(4'b0100));
    wait_idle();

    // Orphan result with nothing outstanding
    drive_edge();
    mq.push_back('{cyc + 1, 64'hDEAD_BEEF_0000_0001});
    @(negedge clk);
    @(negedge clk);
    chk("t5_err_set", 64'(err_orphan), 64'(1));
    chk("t5_no_res_vld", 64'(res_vld), 64'(0));
    drive_edge();
    add_op(3, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    for (t = 0; t < 30; t++) begin
      @(negedge clk);
      if (res_vld != '0) break;
    end
    chk("t5_res_vld", 64'(res_vld), 64'(4'b1000));
    chk("t5_res_data", res_data, 64'h4010_0000_0000_0000);
    chk("t5_err_sticky", 64'(err_orphan), 64'(1));
    wait_idle();

    // Reset with three ops in flight
    mul_lat = 10;
    drive_edge();
    add_op(0, fp(2), fp(5));
    add_op(1, fp(3), fp(5));
    add_op(2, fp(4), fp(5));
    n = 0;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt != '0) n++;
      if (n == 3) break;
    end
    chk("t6_three_grants", 64'(n), 64'(3));
    repeat (2) @(negedge clk);
    drive_edge();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_tvalid", 64'(mul_a_tvalid), 64'(0));
    chk("t6_rst_err", 64'(err_orphan), 64'(0));
    for (int i = 0; i < N; i++) begin op_n[i] = 0; op_i[i] = 0; end
    drive_edge();
    @(negedge clk);
    drive_edge();
    rst_n = 1'b1;
    n = 0;
    for (t = 0; t < 30; t++) begin
      @(negedge clk);
      if (res_vld != '0) n++;
    end
    chk("t6_no_late_res_vld", 64'(n), 64'(0));
    chk("t6_late_err", 64'(err_orphan), 64'(1));
    chk("t6_busy_idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
